// File: rtl/rp_carry_adr_pkg.sv
// Shared constants for the ripple-carry adder slice.
// No logic, no latency.
// No flow control; constants only.
package rp_carry_adr_pkg;

   // Operand width used when an instance does not override WIDTH.
   localparam int ADDER_WIDTH_DEFAULT = 4;

endpackage : rp_carry_adr_pkg

// File: rtl/rp_carry_adr_full_adder.sv
// One-bit full-adder cell, the repeated element of the ripple chain.
// Purely combinational, zero latency.
// No flow control; outputs follow inputs.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic w_axb;

   // Shared half-sum drives both the sum bit and the propagate term.
   assign w_axb = a ^ b;
   assign s     = w_axb ^ cin;
   assign cout  = (a & b) | (cin & w_axb);

endmodule : full_adder

// File: rtl/rp_carry_adr.sv
// Ripple-carry adder a+b+c_in with combinational result and registered result/flags.
// Combinational outputs: 0 cycles; registered outputs: exactly 1 cycle, loaded every edge.
// No backpressure; no enable or handshake, registers capture every rising clk.
module rp_carry_adr
   import rp_carry_adr_pkg::*;
#(
   parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic [WIDTH-1:0] sum_q,
   output logic             c_out_q,
   output logic             ovf_q,
   output logic             zero_q
);

   // w_carry[i] is the carry into cell i; w_carry[WIDTH] leaves the MSB cell.
   logic [WIDTH:0]   w_carry;
   logic [WIDTH-1:0] w_sum;
   logic             w_ovf;
   logic             w_zero;

   logic [WIDTH-1:0] r_sum_q;
   logic             r_c_out_q;
   logic             r_ovf_q;
   logic             r_zero_q;

   assign w_carry[0] = c_in;

   // Carry chain: each cell's carry out feeds the next cell's carry in.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      full_adder u_fa (
         .a    (a[gi]),
         .b    (b[gi]),
         .cin  (w_carry[gi]),
         .s    (w_sum[gi]),
         .cout (w_carry[gi+1])
      );
   end

   assign sum   = w_sum;
   assign c_out = w_carry[WIDTH];

   // Signed overflow: carry into the MSB disagrees with carry out of it.
   assign w_ovf  = w_carry[WIDTH] ^ w_carry[WIDTH-1];
   // Zero looks only at the sum bits; a carry out does not clear it.
   assign w_zero = (w_sum == '0);

   // Output register stage; reset clears all flags, including zero_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum_q   <= '0;
         r_c_out_q <= 1'b0;
         r_ovf_q   <= 1'b0;
         r_zero_q  <= 1'b0;
      end else begin
         r_sum_q   <= w_sum;
         r_c_out_q <= w_carry[WIDTH];
         r_ovf_q   <= w_ovf;
         r_zero_q  <= w_zero;
      end
   end

   assign sum_q   = r_sum_q;
   assign c_out_q = r_c_out_q;
   assign ovf_q   = r_ovf_q;
   assign zero_q  = r_zero_q;

endmodule : rp_carry_adr

// File: tb/tb_rp_carry_adr.sv
// Self-checking bench for rp_carry_adr at WIDTH=4 (exhaustive + directed) and WIDTH=8 (directed).
// Inputs change on the falling edge; registered outputs are sampled 1 time unit after the rising edge.
// No flow control in the design; every vector is one clock.
module tb_rp_carry_adr;

   logic       clk = 1'b0;
   logic       rst_n;

   logic [3:0] a4, b4, sum4, sum_q4;
   logic       c4, c_out4, c_out_q4, ovf_q4, zero_q4;

   logic [7:0] a8, b8, sum8, sum_q8;
   logic       c8, c_out8, c_out_q8, ovf_q8, zero_q8;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   rp_carry_adr #(.WIDTH(4)) u_dut4 (
      .clk     (clk),
      .rst_n   (rst_n),
      .a       (a4),
      .b       (b4),
      .c_in    (c4),
      .sum     (sum4),
      .c_out   (c_out4),
      .sum_q   (sum_q4),
      .c_out_q (c_out_q4),
      .ovf_q   (ovf_q4),
      .zero_q  (zero_q4)
   );

   rp_carry_adr #(.WIDTH(8)) u_dut8 (
      .clk     (clk),
      .rst_n   (rst_n),
      .a       (a8),
      .b       (b8),
      .c_in    (c8),
      .sum     (sum8),
      .c_out   (c_out8),
      .sum_q   (sum_q8),
      .c_out_q (c_out_q8),
      .ovf_q   (ovf_q8),
      .zero_q  (zero_q8)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   // Directed 4-bit vector with hand-computed expectations.
   task automatic vec4(input string tag, input logic [3:0] va, input logic [3:0] vb, input logic vc,
                       input logic [3:0] e_sum, input logic e_co, input logic e_ovf, input logic e_zero);
      @(negedge clk);
      a4 = va; b4 = vb; c4 = vc;
      #1;
      chk({tag, " sum"},   {28'd0, sum4},   {28'd0, e_sum});
      chk({tag, " c_out"}, {31'd0, c_out4}, {31'd0, e_co});
      @(posedge clk);
      #1;
      chk({tag, " sum_q"},   {28'd0, sum_q4},   {28'd0, e_sum});
      chk({tag, " c_out_q"}, {31'd0, c_out_q4}, {31'd0, e_co});
      chk({tag, " ovf_q"},   {31'd0, ovf_q4},   {31'd0, e_ovf});
      chk({tag, " zero_q"},  {31'd0, zero_q4},  {31'd0, e_zero});
   endtask

   // Directed 8-bit vector with hand-computed expectations.
   task automatic vec8(input string tag, input logic [7:0] va, input logic [7:0] vb, input logic vc,
                       input logic [7:0] e_sum, input logic e_co, input logic e_ovf, input logic e_zero);
      @(negedge clk);
      a8 = va; b8 = vb; c8 = vc;
      #1;
      chk({tag, " sum"},   {24'd0, sum8},   {24'd0, e_sum});
      chk({tag, " c_out"}, {31'd0, c_out8}, {31'd0, e_co});
      @(posedge clk);
      #1;
      chk({tag, " sum_q"},   {24'd0, sum_q8},   {24'd0, e_sum});
      chk({tag, " c_out_q"}, {31'd0, c_out_q8}, {31'd0, e_co});
      chk({tag, " ovf_q"},   {31'd0, ovf_q8},   {31'd0, e_ovf});
      chk({tag, " zero_q"},  {31'd0, zero_q8},  {31'd0, e_zero});
   endtask

   initial begin
      int   exp_full;
      logic [3:0] exp_s;
      logic exp_ovf;

      rst_n = 1'b0;
      a4 = 4'd0; b4 = 4'd0; c4 = 1'b0;
      a8 = 8'd0; b8 = 8'd0; c8 = 1'b0;

      // Reset state: registered outputs all zero, zero_q included.
      repeat (2) @(posedge clk);
      #1;
      chk("rst sum_q4",   {28'd0, sum_q4},   32'd0);
      chk("rst c_out_q4", {31'd0, c_out_q4}, 32'd0);
      chk("rst ovf_q4",   {31'd0, ovf_q4},   32'd0);
      chk("rst zero_q4",  {31'd0, zero_q4},  32'd0);
      chk("rst zero_q8",  {31'd0, zero_q8},  32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Exhaustive 4-bit sweep against an arithmetic reference.
      for (int ai = 0; ai < 16; ai++) begin
         for (int bi = 0; bi < 16; bi++) begin
            for (int ci = 0; ci < 2; ci++) begin
               @(negedge clk);
               a4 = ai[3:0]; b4 = bi[3:0]; c4 = ci[0];
               #1;
               exp_full = ai + bi + ci;
               exp_s    = exp_full[3:0];
               exp_ovf  = (ai[3] == bi[3]) && (exp_s[3] != ai[3]);
               chk("ex comb", {27'd0, c_out4, sum4}, exp_full);
               @(posedge clk);
               #1;
               chk("ex reg",  {27'd0, c_out_q4, sum_q4}, exp_full);
               chk("ex ovf",  {31'd0, ovf_q4},  {31'd0, exp_ovf});
               chk("ex zero", {31'd0, zero_q4}, {31'd0, (exp_s == 4'd0)});
            end
         end
      end

      // Boundary vectors.
      vec4("ones+ones+1", 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
      vec4("zero+zero+1", 4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
      vec4("15+1 wrap",   4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1);
      vec4("7+1 ovf",     4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0);

      // Asynchronous reset mid-operation: registers hold 1000 before this.
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid rst sum_q",   {28'd0, sum_q4},   32'd0);
      chk("mid rst c_out_q", {31'd0, c_out_q4}, 32'd0);
      chk("mid rst ovf_q",   {31'd0, ovf_q4},   32'd0);
      chk("mid rst zero_q",  {31'd0, zero_q4},  32'd0);
      chk("mid rst sum",     {28'd0, sum4},     32'h8);
      @(posedge clk);
      #1;
      chk("held rst sum_q", {28'd0, sum_q4}, 32'd0);
      chk("held rst ovf_q", {31'd0, ovf_q4}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("reload sum_q", {28'd0, sum_q4}, 32'h8);
      chk("reload ovf_q", {31'd0, ovf_q4}, 32'd1);

      // 8-bit instance.
      vec8("w8 ff+01+1", 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
      vec8("w8 80+80",   8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
      vec8("w8 7f+01",   8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule : tb_rp_carry_adr

// File: doc/rp_carry_adr.md
Name: rp_carry_adr

Overview:
- Parameterised ripple-carry adder, default 4 bits.
- Computes a + b + c_in through a chain of full-adder cells.
- Outputs:
  - Combinational result: sum, c_out.
  - Registered copy of the result plus status flags, for pipelined datapaths.
- Used as a leaf arithmetic block wherever a small, timing-transparent adder is needed.

Parameters:
- WIDTH, 4, operand and sum width in bits (legal range 1..32).

Ports:
- clk  input  1  rising-edge clock for the registered output stage.
- rst_n  input  1  asynchronous, active-low reset of the registered stage.
- a  input  WIDTH  operand A, unsigned; also read as two's complement for the overflow flag.
- b  input  WIDTH  operand B, same interpretation as a.
- c_in  input  1  carry into bit 0.
- sum  output  WIDTH  combinational sum bits.
- c_out  output  1  combinational carry out of bit WIDTH-1.
- sum_q  output  WIDTH  registered sum.
- c_out_q  output  1  registered carry out.
- ovf_q  output  1  registered signed overflow.
- zero_q  output  1  registered flag: sum equal to zero.

Behaviour:
- Combinational path:
  - {c_out, sum} = a + b + c_in, exact (WIDTH+1)-bit result, no saturation.
  - Wrap-around modulo 2^WIDTH on sum.
  - Zero latency; no dependency on clk or rst_n.
- Ripple structure:
  - Carry of cell i feeds c_in of cell i+1.
  - Cell 0 takes c_in; the last cell's carry is c_out.
  - Each cell: s = x ^ y ^ ci; co = (x & y) | (ci & (x ^ y)).
- Signed overflow: carry into MSB XOR carry out of MSB (equivalently, operand MSBs equal and sum MSB differs).
- Registered stage:
  - On every rising clk edge: sum_q <= sum, c_out_q <= c_out, ovf_q <= overflow, zero_q <= (sum == 0).
  - Latency is exactly 1 cycle; there is no enable and no handshake; registers load every cycle.
- Reset:
  - rst_n low asynchronously forces sum_q = 0, c_out_q = 0, ovf_q = 0, zero_q = 0.
  - Held while rst_n is low.
  - First load occurs on the first rising clk edge after rst_n deasserts.
  - Reset never affects sum or c_out.
  - zero_q resets to 0 (not 1), even though the reset sum_q is zero.
- Boundary cases:
  - All-ones operands with c_in = 1: sum = all-ones, c_out = 1.
  - All-zero operands with c_in = 1: sum = 1, c_out = 0.
  - zero_q is 1 only when every sum bit is 0, regardless of c_out (e.g. 15+1+0 at WIDTH=4 gives zero_q = 1, c_out_q = 1).
- No X propagation from reset onto the combinational outputs; inputs are assumed driven.

Decomposition:
- Shared package:
  - Default width constant ADDER_WIDTH_DEFAULT = 4.
  - No typedefs required.
- One natural sub-module: full_adder (inputs a, b, cin; outputs s, cout), instantiated WIDTH times by a generate loop.
- Top module: carry chain, overflow logic, zero detect, registered stage.

Test Plan:
- Exhaustive: all 16x16 operand pairs at WIDTH=4, each with c_in = 0 then c_in = 1 (512 vectors, 10 time units apart) -> {c_out, sum} == a + b + c_in on every vector; sum_q/c_out_q match the previous cycle's values.
- a=1111, b=1111, c_in=1 -> sum=1111, c_out=1; next edge ovf_q=0, zero_q=0.
- a=0111, b=0001, c_in=0 -> sum=1000, c_out=0; next edge ovf_q=1.
- a=1111, b=0001, c_in=0 -> sum=0000, c_out=1; next edge zero_q=1, c_out_q=1.
- Reset mid-operation:
  - Registered outputs loaded with 1000.
  - Assert rst_n=0 between clock edges -> sum_q/c_out_q/ovf_q/zero_q go to 0 immediately while sum stays 1000.
  - Release rst_n -> reload on the next rising edge.
- WIDTH=8 instance: a=0xFF, b=0x01, c_in=1 -> sum=0x01, c_out=1; a=0x80, b=0x80 -> sum=0x00, c_out=1, ovf_q=1, zero_q=1.
